// File: rtl/iom_bus_target_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus target.
//   iom_state_e   : bus-cycle FSM states
//   DevMem/DevIo  : device-type encodings for IS_IO
//   Mem*/Io*      : default address windows of the four system instances
//   offset_width  : array index width for a given depth (never zero)
package iom_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StRead,
    StWrite
  } iom_state_e;

  localparam int unsigned DevMem = 0;
  localparam int unsigned DevIo  = 1;

  localparam logic [19:0] Mem0Base = 20'h00000;
  localparam logic [19:0] Mem0End  = 20'h7FFFF;
  localparam logic [19:0] Mem1Base = 20'h80000;
  localparam logic [19:0] Mem1End  = 20'hFFFFF;
  localparam logic [19:0] Io0Base  = 20'h0FF00;
  localparam logic [19:0] Io0End   = 20'h0FF0F;
  localparam logic [19:0] Io1Base  = 20'h01C00;
  localparam logic [19:0] Io1End   = 20'h01DFF;

  function automatic int unsigned offset_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/iom_bus_target_if.sv
// Demultiplexed 8088 bus control/address bundle, as seen after the address latch
// and chip-select decoder. The data bus is kept as a separate inout net.
//   ALE     : address latch enable (T1)
//   RD, WR  : active-low strobes
//   IOM     : 1 = I/O cycle, 0 = memory cycle
//   Address : latched 20-bit address
//   CS      : one-hot chip selects
// modport master drives the bundle (CPU side / bench), slave receives it (targets).
interface iom_bus_if;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic [19:0] Address;
  logic [3:0]  CS;

  modport master (output ALE, RD, WR, IOM, Address, CS);
  modport slave  (input  ALE, RD, WR, IOM, Address, CS);
endinterface

// File: rtl/iom_byte_ram.sv
// Byte array behind the bus target: one synchronous write port and one
// asynchronous read port sharing a single address.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : byte index
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
// Build option IOM_PRELOAD_EN: contents start as byte[k] = k[7:0]; otherwise
// contents are undefined until written. The array is never reset.
module iom_byte_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = iom_pkg::offset_width(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

`ifdef IOM_PRELOAD_EN
  typedef logic [7:0] mem_t [Depth];

  function automatic mem_t preload_image();
    mem_t img;
    for (int unsigned k = 0; k < Depth; k++) begin
      img[k] = 8'(k);
    end
    return img;
  endfunction

  logic [7:0] mem_q [Depth] = preload_image();
`else
  logic [7:0] mem_q [Depth];
`endif

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/iom_bus_target.sv
// Byte-wide memory or I/O target on a demultiplexed 8088 minimum-mode bus.
// A cycle is claimed on ALE when this device's chip select is active, the
// IOM type matches and the address lies in [BASE_ADDR, END_ADDR]; the FSM then
// serves exactly one read or write strobe and returns to idle.
//   CLK     : bus clock
//   RESET   : asynchronous, active-high reset (FSM and offset only)
//   bus     : iom_bus_if.slave (ALE, RD, WR, IOM, Address, CS)
//   Data    : buffered data bus, driven only while serving a read with RD low
// Build option IOM_PRELOAD_EN (see iom_byte_ram): array preloaded with byte[k] = k.
module iom_bus_target
  import iom_pkg::*;
#(
  parameter int unsigned IS_IO     = DevMem,
  parameter logic [19:0] BASE_ADDR = Mem0Base,
  parameter logic [19:0] END_ADDR  = Mem0End,
  parameter int unsigned CS_BIT    = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  iom_bus_if.slave   bus,
  inout  wire  [7:0] Data
);

  localparam int unsigned Depth = 32'(END_ADDR - BASE_ADDR) + 32'd1;
  localparam int unsigned OffW  = offset_width(Depth);
  localparam bit          IoDev = (IS_IO != DevMem);

  iom_state_e      state_q, state_d;
  logic [OffW-1:0] off_q, off_d;

  logic [19:0] addr_eff;
  logic [19:0] offset_full;
  logic        sel;
  logic        in_win;
  logic        ram_we;
  logic        drive;
  logic [7:0]  ram_rdata;

  // I/O space is 64 KB: upper address bits are ignored by I/O devices.
  assign addr_eff    = IoDev ? {4'h0, bus.Address[15:0]} : bus.Address;
  assign offset_full = addr_eff - BASE_ADDR;
  assign sel         = bus.CS[CS_BIT] && (bus.IOM == IoDev);
  // Window check on the full 20-bit offset, so nothing aliases after truncation.
  assign in_win      = (addr_eff >= BASE_ADDR) && (offset_full <= (END_ADDR - BASE_ADDR));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    ram_we  = 1'b0;
    drive   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // sel is only looked at here; later CS changes cannot abort the cycle.
        if (bus.ALE && sel && in_win) begin
          state_d = StAddr;
          off_d   = offset_full[OffW-1:0];
        end
      end
      StAddr: begin
        // RD takes priority if both strobes are low.
        if (!bus.RD) begin
          state_d = StRead;
        end else if (!bus.WR) begin
          state_d = StWrite;
        end
      end
      StRead: begin
        drive = !bus.RD;
        if (bus.RD) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        // Written on every edge with WR low: the last sampled byte sticks.
        ram_we = !bus.WR;
        if (bus.WR) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  iom_byte_ram #(
    .Depth (Depth),
    .AddrW (OffW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .addr_i  (off_q),
    .wdata_i (Data),
    .rdata_o (ram_rdata)
  );

  assign Data = drive ? ram_rdata : 8'bz;

endmodule

// File: tb/tb_iom_bus_target.sv
// Directed bench: the four system instances (MEM0, MEM1, IO0, IO1) share one
// bus bundle, each on its own data net with a pull-up, so an undriven net
// reads 8'hFF and any stray drive shows up on that instance's net.
module tb_iom_bus_target;
  import iom_pkg::*;

  logic clk;
  logic rst;
  logic       drv_en;
  logic [7:0] drv_val;
  int unsigned n_checks;
  int unsigned n_errors;

  wire [7:0] data0;
  wire [7:0] data1;
  wire [7:0] data2;
  wire [7:0] data3;

  iom_bus_if bus ();

  pullup (data0);
  pullup (data1);
  pullup (data2);
  pullup (data3);

  assign data0 = drv_en ? drv_val : 8'bz;
  assign data1 = drv_en ? drv_val : 8'bz;
  assign data2 = drv_en ? drv_val : 8'bz;
  assign data3 = drv_en ? drv_val : 8'bz;

  iom_bus_target #(
    .IS_IO(DevMem), .BASE_ADDR(Mem0Base), .END_ADDR(Mem0End), .CS_BIT(0)
  ) u_mem0 (
    .CLK(clk), .RESET(rst), .bus(bus), .Data(data0)
  );

  iom_bus_target #(
    .IS_IO(DevMem), .BASE_ADDR(Mem1Base), .END_ADDR(Mem1End), .CS_BIT(1)
  ) u_mem1 (
    .CLK(clk), .RESET(rst), .bus(bus), .Data(data1)
  );

  iom_bus_target #(
    .IS_IO(DevIo), .BASE_ADDR(Io0Base), .END_ADDR(Io0End), .CS_BIT(2)
  ) u_io0 (
    .CLK(clk), .RESET(rst), .bus(bus), .Data(data2)
  );

  iom_bus_target #(
    .IS_IO(DevIo), .BASE_ADDR(Io1Base), .END_ADDR(Io1End), .CS_BIT(3)
  ) u_io1 (
    .CLK(clk), .RESET(rst), .bus(bus), .Data(data3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] data_of(int i);
    case (i)
      0:       return data0;
      1:       return data1;
      2:       return data2;
      default: return data3;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // dev = instance expected to drive exp; every other net must read released (FF).
  task automatic check_bus(input string tag, input int dev, input logic [7:0] exp);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s dev%0d", tag, i), data_of(i), (i == dev) ? exp : 8'hFF);
    end
  endtask

  // Five-clock write; d_first is sampled on one edge and d_last on the next.
  task automatic bus_write(input logic [19:0] a, input logic iom, input logic [3:0] cs,
                           input logic [7:0] d_first, input logic [7:0] d_last);
    @(negedge clk);
    bus.ALE = 1'b1; bus.Address = a; bus.IOM = iom; bus.CS = cs;
    @(negedge clk);
    bus.ALE = 1'b0; bus.CS = 4'h0; bus.WR = 1'b0; drv_en = 1'b1; drv_val = d_first;
    @(negedge clk);
    @(negedge clk);
    drv_val = d_last;
    @(negedge clk);
    bus.WR = 1'b1; drv_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input string tag, input logic [19:0] a, input logic iom,
                          input logic [3:0] cs, input int dev, input logic [7:0] exp,
                          input logic wr_too);
    @(negedge clk);
    bus.ALE = 1'b1; bus.Address = a; bus.IOM = iom; bus.CS = cs;
    @(negedge clk);
    bus.ALE = 1'b0; bus.CS = 4'h0; bus.RD = 1'b0; bus.WR = ~wr_too;
    #1 check_bus({tag, " pre"}, -1, 8'h00);
    @(posedge clk);
    #1 check_bus(tag, dev, exp);
    @(negedge clk);
    bus.RD = 1'b1; bus.WR = 1'b1;
    #1 check_bus({tag, " rel"}, -1, 8'h00);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drv_en = 1'b0; drv_val = 8'h00;
    bus.ALE = 1'b0; bus.RD = 1'b1; bus.WR = 1'b1; bus.IOM = 1'b0;
    bus.Address = 20'h0; bus.CS = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_bus("reset", -1, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Memory bank 0 write/read.
    bus_write(20'h00123, 1'b0, 4'b0001, 8'hA5, 8'hA5);
    bus_read("mem0 rd", 20'h00123, 1'b0, 4'b0001, 0, 8'hA5, 1'b0);

    // Last sampled write byte wins.
    bus_write(20'h00200, 1'b0, 4'b0001, 8'h11, 8'hE7);
    bus_read("mem0 last", 20'h00200, 1'b0, 4'b0001, 0, 8'hE7, 1'b0);

    // Bank 1 offset, and no aliasing onto bank 0 at the same offset.
    bus_write(20'h00004, 1'b0, 4'b0001, 8'hC3, 8'hC3);
    bus_write(20'h80004, 1'b0, 4'b0010, 8'h3C, 8'h3C);
    bus_read("mem1 rd", 20'h80004, 1'b0, 4'b0010, 1, 8'h3C, 1'b0);
    bus_read("mem0 off4", 20'h00004, 1'b0, 4'b0001, 0, 8'hC3, 1'b0);

    // IO0: memory cycles are ignored; upper address bits ignored for I/O.
    bus_write(20'h0FF02, 1'b1, 4'b0100, 8'h5B, 8'h5B);
    bus_write(20'h0FF02, 1'b0, 4'b0100, 8'h99, 8'h99);
    bus_read("io0 iom0", 20'h0FF02, 1'b0, 4'b0100, -1, 8'h00, 1'b0);
    bus_read("io0 rd", 20'h0FF02, 1'b1, 4'b0100, 2, 8'h5B, 1'b0);
    bus_read("io0 hi", 20'h3FF02, 1'b1, 4'b0100, 2, 8'h5B, 1'b0);

    // IO1 out-of-window: 1E00 would alias onto 1C00 if truncated.
    bus_write(20'h01C00, 1'b1, 4'b1000, 8'h11, 8'h11);
    bus_write(20'h01E00, 1'b1, 4'b1000, 8'h77, 8'h77);
    bus_read("io1 oow", 20'h01E00, 1'b1, 4'b1000, -1, 8'h00, 1'b0);
    bus_read("io1 rd", 20'h01C00, 1'b1, 4'b1000, 3, 8'h11, 1'b0);

    // RD and WR both low: read wins and nothing is written.
    bus_read("rd+wr", 20'h00123, 1'b0, 4'b0001, 0, 8'hA5, 1'b1);
    bus_read("after rd+wr", 20'h00123, 1'b0, 4'b0001, 0, 8'hA5, 1'b0);

    // Asynchronous reset in the middle of a read releases the bus at once.
    @(negedge clk);
    bus.ALE = 1'b1; bus.Address = 20'h00123; bus.IOM = 1'b0; bus.CS = 4'b0001;
    @(negedge clk);
    bus.ALE = 1'b0; bus.CS = 4'h0; bus.RD = 1'b0;
    @(posedge clk);
    #1 check_bus("pre-reset rd", 0, 8'hA5);
    #1 rst = 1'b1;
    #1 check_bus("reset mid-rd", -1, 8'h00);
    @(negedge clk);
    rst = 1'b0; bus.RD = 1'b1;
    bus_read("post-reset rd", 20'h00123, 1'b0, 4'b0001, 0, 8'hA5, 1'b0);

`ifdef IOM_PRELOAD_EN
    bus_read("preload", 20'h80047, 1'b0, 4'b0010, 1, 8'h47, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iom_bus_target.md
Name: iom_bus_target

Overview:
- Byte-wide memory or I/O target on a demultiplexed Intel 8088 minimum-mode bus.
- Sits behind the system address latch, the 8286 transceiver and the external chip-select decoder.
- Responds to read/write bus cycles in its window with a small state machine and an internal byte array.
- Instantiated 4× per system: two 512 KB memory banks, two I/O blocks.

Parameters:
- IS_IO, 0 — 0 = memory device (responds when IOM=0); 1 = I/O device (responds when IOM=1).
- BASE_ADDR, 20'h00000 — first address of the window.
- END_ADDR, 20'h7FFFF — last address of the window, inclusive. Array depth = END_ADDR-BASE_ADDR+1.
- CS_BIT, 0 — index of this device's line within the CS vector.

Ports:
- CLK  input  1  bus clock.
- RESET  input  1  asynchronous, active-high reset.
- ALE  input  1  address latch enable (high during T1).
- RD  input  1  read strobe, active low.
- WR  input  1  write strobe, active low.
- IOM  input  1  1 = I/O cycle, 0 = memory cycle.
- Address  input  20  latched address; I/O devices use bits [15:0], upper bits ignored.
- Data  inout  8  buffered data bus; driven only during reads, else high-Z.
- CS  input  4  one-hot chip selects from the system decoder.

Behaviour:
- sel = CS[CS_BIT] && (IOM == IS_IO).
- offset = Address - BASE_ADDR, computed at 20 bits and truncated to clog2(depth) bits.
- States: IDLE, ADDR, READ, WRITE. All transitions on posedge CLK.
- IDLE:
  - ALE && sel → ADDR; capture offset into register `off`.
  - Otherwise stay in IDLE.
- ADDR:
  - RD==0 → READ.
  - else WR==0 → WRITE.
  - else hold.
  - RD and WR both low: RD wins.
- READ:
  - Data = mem[off] combinationally while state==READ and RD==0.
  - RD==1 → IDLE; Data released to 'z in the same cycle RD rises.
- WRITE:
  - mem[off] <= Data on every posedge with WR==0, so the last sampled value wins.
  - WR==1 → IDLE.
- Data is 'z in every other state/condition. The module never drives while RD is high.
- ALE seen in READ/WRITE is ignored until the FSM returns to IDLE.
- sel is sampled only on the ALE cycle. Later CS changes do not abort a cycle.
- Address outside [BASE_ADDR, END_ADDR] with sel asserted: access is ignored; FSM goes IDLE→IDLE. No wrap-around, no aliasing.
- RESET (async, any time including mid-cycle): state=IDLE, off=0, Data='z immediately. Array contents are not reset.
- Latency: read data valid on the bus from the first posedge after RD falls (T3 of a 4-clock 8088 cycle). No wait states; no READY output.

Optional Feature:
- Macro IOM_PRELOAD_EN.
- Defined: the array is initialised at time 0 so byte[k] = k[7:0] (k = offset).
- Undefined: contents are X until written; reads of unwritten locations return X.
- Reset behaviour is identical in both builds.

Decomposition:
- Package iom_pkg: state enum typedef {IDLE, ADDR, READ, WRITE}; constants DEV_MEM=0 and DEV_IO=1; default window constants MEM0 00000-7FFFF, MEM1 80000-FFFFF, IO0 FF00-FF0F, IO1 1C00-1DFF.
- One natural sub-module, iom_byte_ram: parameterised depth, one sync write port, one async read port, holds the preload logic.
- FSM, select logic and tristate stay in the top.

Test Plan:
- Reset mid-read: RESET pulse while in READ → Data='z same cycle, state IDLE; next cycle with ALE accepted.
- Memory write/read: IS_IO=0, BASE 00000, CS[0]=1, IOM=0, write 8'hA5 to 00123, then read 00123 → Data=8'hA5 during RD low, 'z otherwise.
- Bank 1 offset: IS_IO=0, BASE 80000, CS_BIT=1, write 8'h3C to 80004 → read 80004 returns 8'h3C; bank 0 instance never drives.
- I/O mismatch: IS_IO=1, BASE FF00, IOM=0 cycle to FF02 → no response, Data stays 'z; same cycle with IOM=1 → responds.
- Out-of-window: IO1 (1C00-1DFF) with CS[3]=1, address 1E00 → ignored; no write, no drive.
- Preload (IOM_PRELOAD_EN defined): read BASE+0x47 with no prior write → 8'h47.
